// File: rtl/splitter_stream.sv
// splitter_stream
//
// Buffers wide input words in a small DEPTH-entry FIFO and streams each word
// out as N = INPUT_WIDTH/OUTPUT_WIDTH narrow slices, one slice per cycle.
// Sits between wide producers (packed polynomial/coefficient words arriving
// from the AXI side) and the narrow consumers of the Kyber datapath.
//
// Configuration macro:
//   SPLITTER_LSB_FIRST_EN  - when defined, the least significant slice of a
//                            word is emitted first; otherwise the most
//                            significant slice goes first.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset_n    synchronous active-low reset
//   i_flush      synchronous clear of the word buffer and output stage
//   i_in_valid   input word valid
//   i_data_in    input word (INPUT_WIDTH bits)
//   o_in_ready   input word accepted when i_in_valid && o_in_ready
//   o_out_valid  o_data_out holds a valid slice
//   i_out_ready  consumer takes the slice when o_out_valid && i_out_ready
//   o_data_out   current slice (registered, OUTPUT_WIDTH bits)
//   o_last       current slice is the final slice of its word
//   o_level      words held, including the word currently being sliced
//   o_full       o_level == DEPTH
//   o_empty      o_level == 0 and no slice presented
module splitter_stream #(
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 8,
    parameter int N            = INPUT_WIDTH / OUTPUT_WIDTH,
    parameter int DEPTH        = 2,
    parameter int LVL_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_flush,
    input  logic                    i_in_valid,
    input  logic [INPUT_WIDTH-1:0]  i_data_in,
    output logic                    o_in_ready,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [OUTPUT_WIDTH-1:0] o_data_out,
    output logic                    o_last,
    output logic [LVL_WIDTH-1:0]    o_level,
    output logic                    o_full,
    output logic                    o_empty
);

    // DEPTH is a power of two, so pointers wrap naturally in binary.
    localparam int PTR_WIDTH = $clog2(DEPTH);
    // Keep the slice index at least one bit wide so N=1 stays legal.
    localparam int IDX_WIDTH = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(N - 1);
    localparam logic [LVL_WIDTH-1:0] LVL_FULL  = LVL_WIDTH'(DEPTH);
    localparam logic [LVL_WIDTH-1:0] LVL_ZERO  = '0;
    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1);

    // Word storage and bookkeeping registers
    logic [INPUT_WIDTH-1:0]  mem_q [DEPTH];
    logic [INPUT_WIDTH-1:0]  mem_d [DEPTH];
    logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [IDX_WIDTH-1:0]    slice_idx_q, slice_idx_d;
    logic [LVL_WIDTH-1:0]    level_q, level_d;

    // Output stage registers
    logic                    out_valid_q, out_valid_d;
    logic [OUTPUT_WIDTH-1:0] data_out_q, data_out_d;
    logic                    last_q, last_d;

    // Per-cycle control
    logic                    in_ready;
    logic                    in_fire;
    logic                    load;
    logic                    is_last_slice;
    logic                    free_word;
    logic [INPUT_WIDTH-1:0]  cur_word;
    logic [OUTPUT_WIDTH-1:0] cur_slice;

    // Ready depends only on the registered level and flush: a slot freed this
    // cycle is not offered to the producer until the next cycle.
    always_comb begin
        in_ready      = !i_flush && (level_q < LVL_FULL);
        in_fire       = i_in_valid && in_ready;
        load          = (level_q != LVL_ZERO) && (!out_valid_q || i_out_ready);
        is_last_slice = (slice_idx_q == LAST_IDX);
        free_word     = load && is_last_slice;
    end

    // Pick the slice at slice_idx out of the word at the read pointer.
    always_comb begin
        cur_word  = mem_q[rd_ptr_q];
        cur_slice = '0;
        for (int k = 0; k < N; k++) begin
            if (slice_idx_q == IDX_WIDTH'(k)) begin
`ifdef SPLITTER_LSB_FIRST_EN
                cur_slice = cur_word[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
`else
                cur_slice = cur_word[INPUT_WIDTH-1-k*OUTPUT_WIDTH -: OUTPUT_WIDTH];
`endif
            end
        end
    end

    // Buffer write: an accepted word lands at the write pointer.
    always_comb begin
        mem_d = mem_q;
        if (in_fire) begin
            mem_d[wr_ptr_q] = i_data_in;
        end
    end

    // Next-state for pointers, level and the output register. A word is
    // released from the buffer as soon as its last slice is copied into the
    // output register, so accept and free in one cycle leave level unchanged.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        slice_idx_d = slice_idx_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        last_d      = last_q;

        if (i_flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            slice_idx_d = '0;
            level_d     = '0;
            out_valid_d = 1'b0;
            last_d      = 1'b0;
        end else begin
            if (in_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end

            if (load) begin
                data_out_d  = cur_slice;
                out_valid_d = 1'b1;
                last_d      = is_last_slice;
                if (is_last_slice) begin
                    slice_idx_d = '0;
                    rd_ptr_d    = rd_ptr_q + PTR_ONE;
                end else begin
                    slice_idx_d = slice_idx_q + IDX_ONE;
                end
            end else if (out_valid_q && i_out_ready) begin
                out_valid_d = 1'b0;
            end

            level_d = level_q + LVL_WIDTH'(in_fire) - LVL_WIDTH'(free_word);
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            slice_idx_q <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            last_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            slice_idx_q <= slice_idx_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            last_q      <= last_d;
        end
    end

    // Word storage needs no reset: entries are only read once level covers them.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_in_ready  = in_ready;
    assign o_out_valid = out_valid_q;
    assign o_data_out  = data_out_q;
    assign o_last      = last_q;
    assign o_level     = level_q;
    assign o_full      = (level_q == LVL_FULL);
    assign o_empty     = (level_q == LVL_ZERO) && !out_valid_q;

endmodule

// File: tb/tb_splitter_stream.sv
// tb_splitter_stream
//
// Self-checking bench for splitter_stream at INPUT_WIDTH=32, OUTPUT_WIDTH=8,
// DEPTH=2. A queue-based reference model tracks the words held and the
// presented slice; every cycle the DUT outputs are compared with it, and
// directed sequences add hard-coded expectations for the key scenarios.
module tb_splitter_stream;

    localparam int IW    = 32;
    localparam int OW    = 8;
    localparam int N     = IW / OW;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [IW-1:0] data_in;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] data_out;
    logic          last;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [IW-1:0] m_words[$];
    int            m_sidx;
    logic          m_valid;
    logic [OW-1:0] m_data;
    logic          m_last;
    bit            m_accepted;

    typedef struct {
        logic          in_valid;
        logic [IW-1:0] data;
        logic          out_ready;
        logic          exp_valid;
        logic [OW-1:0] exp_data;
        logic          exp_last;
        logic [LW-1:0] exp_level;
        logic          exp_empty;
    } vec_t;

    vec_t vecs[15];

    splitter_stream #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .DEPTH       (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_flush    (flush),
        .i_in_valid (in_valid),
        .i_data_in  (data_in),
        .o_in_ready (in_ready),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_data_out (data_out),
        .o_last     (last),
        .o_level    (level),
        .o_full     (full),
        .o_empty    (empty)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Slice k of a word, straight from the slice-order rule
    function automatic logic [OW-1:0] sliceOf(input logic [IW-1:0] w, input int k);
`ifdef SPLITTER_LSB_FIRST_EN
        return OW'(w >> (k * OW));
`else
        return OW'(w >> ((N - 1 - k) * OW));
`endif
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model over one rising edge using the inputs now applied
    task automatic modelUpdate();
        int  lvl;
        bit  acc;
        bit  ld;
        m_accepted = 1'b0;
        if (!rst_n) begin
            m_words.delete();
            m_sidx  = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_last  = 1'b0;
        end else if (flush) begin
            m_words.delete();
            m_sidx  = 0;
            m_valid = 1'b0;
            m_last  = 1'b0;
        end else begin
            lvl = m_words.size();
            acc = in_valid && (lvl < DEPTH);
            ld  = (lvl > 0) && (!m_valid || out_ready);
            if (ld) begin
                m_data  = sliceOf(m_words[0], m_sidx);
                m_last  = (m_sidx == N - 1);
                m_valid = 1'b1;
                m_sidx++;
                if (m_sidx == N) begin
                    m_sidx = 0;
                    void'(m_words.pop_front());
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (acc) begin
                m_words.push_back(data_in);
            end
            m_accepted = acc;
        end
    endtask

    task automatic checkOutput();
        int lvl;
        lvl = m_words.size();
        checkValue("out_valid", 32'(out_valid), 32'(m_valid));
        checkValue("data_out", 32'(data_out), 32'(m_data));
        if (m_valid) checkValue("last", 32'(last), 32'(m_last));
        checkValue("level", 32'(level), 32'(lvl));
        checkValue("full", 32'(full), 32'(lvl == DEPTH));
        checkValue("empty", 32'(empty), 32'((lvl == 0) && !m_valid));
        checkValue("in_ready", 32'(in_ready), 32'(!flush && (lvl < DEPTH)));
    endtask

    task automatic applyStimulus(input logic iv, input logic [IW-1:0] d,
                                 input logic ordy, input logic fl);
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One clock: model update, edge, then sample 1 time unit later
    task automatic tick();
        modelUpdate();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [OW-1:0] exp12[12];
        logic [IW-1:0] w;
        bit            p4_acc;

        n_checks = 0;
        n_fail   = 0;
        m_sidx   = 0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_last   = 1'b0;

        // Vector table: single word streamed, then the same word with a stall
        vecs[0]  = '{1'b1, 32'hAABBCCDD, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hAA, 1'b0, 2'd1, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hBB, 1'b0, 2'd1, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hCC, 1'b0, 2'd1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hDD, 1'b1, 2'd0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
        vecs[6]  = '{1'b1, 32'hAABBCCDD, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hAA, 1'b0, 2'd1, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hBB, 1'b0, 2'd1, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'hBB, 1'b0, 2'd1, 1'b0};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'hBB, 1'b0, 2'd1, 1'b0};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'hBB, 1'b0, 2'd1, 1'b0};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hCC, 1'b0, 2'd1, 1'b0};
        vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hDD, 1'b1, 2'd0, 1'b0};
        vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};

`ifdef SPLITTER_LSB_FIRST_EN
        $display("[TB] slice order: LSB first");
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].exp_valid) begin
                case (vecs[i].exp_data)
                    8'hAA:   vecs[i].exp_data = 8'hDD;
                    8'hBB:   vecs[i].exp_data = 8'hCC;
                    8'hCC:   vecs[i].exp_data = 8'hBB;
                    default: vecs[i].exp_data = 8'hAA;
                endcase
            end
        end
`else
        $display("[TB] slice order: MSB first");
`endif

        // Reset held low for two cycles with random traffic
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom), $urandom, 1'($urandom), 1'b0);
            tick();
        end
        checkValue("rst_out_valid", 32'(out_valid), 32'd0);
        checkValue("rst_data_out", 32'(data_out), 32'd0);
        checkValue("rst_level", 32'(level), 32'd0);
        checkValue("rst_empty", 32'(empty), 32'd1);
        checkValue("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Table-driven streaming and stall
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].in_valid, vecs[i].data, vecs[i].out_ready, 1'b0);
            tick();
            checkValue($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkValue($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
                checkValue($sformatf("vec%0d_last", i), 32'(last), 32'(vecs[i].exp_last));
            end
            checkValue($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            checkValue($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
        end

        // Fill the buffer with the consumer stalled, then drain three words
        applyStimulus(1'b1, 32'h11223344, 1'b0, 1'b0);
        tick();
        checkValue("p4_level1", 32'(level), 32'd1);
        applyStimulus(1'b1, 32'h55667788, 1'b0, 1'b0);
        tick();
        checkValue("p4_level2", 32'(level), 32'd2);
        checkValue("p4_full", 32'(full), 32'd1);
        checkValue("p4_first", 32'(data_out), 32'(sliceOf(32'h11223344, 0)));
        applyStimulus(1'b1, 32'h99AABBCC, 1'b0, 1'b0);
        #1;
        checkValue("p4_stall_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkValue("p4_hold_valid", 32'(out_valid), 32'd1);
            checkValue("p4_hold_data", 32'(data_out), 32'(sliceOf(32'h11223344, 0)));
        end
        for (int k = 0; k < N; k++) begin
            exp12[k]         = sliceOf(32'h11223344, k);
            exp12[N + k]     = sliceOf(32'h55667788, k);
            exp12[2 * N + k] = sliceOf(32'h99AABBCC, k);
        end
        p4_acc    = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i < 12; i++) begin
            tick();
            if (m_accepted) begin
                p4_acc   = 1'b1;
                in_valid = 1'b0;
            end
            checkValue($sformatf("p4_stream_valid%0d", i), 32'(out_valid), 32'd1);
            checkValue($sformatf("p4_stream_data%0d", i), 32'(data_out), 32'(exp12[i]));
            checkValue($sformatf("p4_stream_last%0d", i), 32'(last), 32'((i % N) == N - 1));
            if (i == N - 1) begin
                checkValue("p4_ready_after_free", 32'(in_ready), 32'd1);
            end
        end
        checkValue("p4_third_accepted", 32'(p4_acc), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkValue("p4_drained_empty", 32'(empty), 32'd1);

        // Flush while a word is partly sliced; dropped input that cycle
        applyStimulus(1'b1, 32'hAABBCCDD, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        checkValue("p5_third_slice", 32'(data_out), 32'(sliceOf(32'hAABBCCDD, 2)));
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        #1;
        checkValue("p5_flush_ready", 32'(in_ready), 32'd0);
        tick();
        checkValue("p5_flush_valid", 32'(out_valid), 32'd0);
        checkValue("p5_flush_level", 32'(level), 32'd0);
        checkValue("p5_flush_empty", 32'(empty), 32'd1);
        applyStimulus(1'b1, 32'h01020304, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkValue("p5_next_valid", 32'(out_valid), 32'd1);
        checkValue("p5_next_data", 32'(data_out), 32'(sliceOf(32'h01020304, 0)));
        tick();
        tick();
        tick();
        checkValue("p5_next_last", 32'(last), 32'd1);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            applyStimulus(1'($urandom_range(0, 1)), w,
                          1'($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 99) < 3));
            tick();
        end

        // Mid-operation reset also clears the presented data
        applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checkValue("midrst_data", 32'(data_out), 32'd0);
        checkValue("midrst_valid", 32'(out_valid), 32'd0);
        checkValue("midrst_level", 32'(level), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/splitter_stream.md
Name: splitter_stream

Overview:
- Parametrised successor to the single-word width splitter.
- Accepts wide words through a valid/ready handshake into a DEPTH-entry word buffer and streams each word out as N = INPUT_WIDTH/OUTPUT_WIDTH narrow slices, one per cycle.
- Output side uses valid/ready with a last-slice marker.
- Sits between wide producers (packed polynomial/coefficient words from the AXI side) and narrow consumers inside the Kyber datapath.

Parameters:
- INPUT_WIDTH, 32, width of one input word; must be an integer multiple of OUTPUT_WIDTH.
- OUTPUT_WIDTH, 8, width of one output slice.
- N, INPUT_WIDTH/OUTPUT_WIDTH, slices per word (derived; N=1 legal).
- DEPTH, 2, buffered input words; power of two, >=2.
- LVL_WIDTH, $clog2(DEPTH+1), width of o_level.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_flush  in  1  synchronous clear of buffer and output stage.
- i_in_valid  in  1  input word valid.
- i_data_in  in  INPUT_WIDTH  input word.
- o_in_ready  out  1  input word accepted when i_in_valid && o_in_ready at the clock edge.
- o_out_valid  out  1  o_data_out holds a valid slice.
- i_out_ready  in  1  consumer takes the slice when o_out_valid && i_out_ready.
- o_data_out  out  OUTPUT_WIDTH  current slice (registered).
- o_last  out  1  current slice is the final slice of its word.
- o_level  out  LVL_WIDTH  number of words held, including the word currently being sliced.
- o_full  out  1  o_level == DEPTH.
- o_empty  out  1  o_level == 0 && !o_out_valid.

Behaviour:
- One clock domain. Reset is synchronous and active-low, sampled on the i_clk rising edge. Priority: reset > flush > normal operation.
- Reset values: o_out_valid=0, o_data_out=0, o_last=0, o_level=0, o_full=0, o_empty=1. Write pointer, read pointer and slice index all reset to 0. Buffer contents are don't-care.
- o_in_ready = !i_flush && (o_level < DEPTH). This is combinational from registered level and i_flush only, with no same-cycle pass-through of a freed slot.
- Accept: the word is written at wr_ptr, wr_ptr increments modulo DEPTH, level increments.
- Slice order (default): slice k = i_data_in[INPUT_WIDTH-1-k*OUTPUT_WIDTH -: OUTPUT_WIDTH], i.e. MSB slice first.
- Output register load condition: level>0 && (!o_out_valid || i_out_ready).
  - On load: o_data_out <= slice[slice_idx] of the word at rd_ptr; o_out_valid <= 1; o_last <= (slice_idx == N-1).
  - slice_idx then increments. On reaching N-1 it wraps to 0, rd_ptr increments modulo DEPTH, and level decrements (the word is freed once its last slice is loaded).
- If no load occurs and the output handshake completes, o_out_valid <= 0. If no handshake occurs, o_data_out, o_last and o_out_valid hold stable.
- Latency: a word accepted at edge E is first presented after edge E+1. With i_out_ready held high, throughput is one slice per cycle, and back-to-back words produce no bubble.
- Accept and free in the same cycle: level unchanged.
- N=1: every slice has o_last=1, and each load frees its word.
- i_flush=1: on that edge, level, pointers and slice_idx clear to 0 and o_out_valid/o_last clear to 0. Any input presented that cycle is dropped (o_in_ready=0). A partially sliced word is discarded.
- Mid-operation reset: identical to flush and also clears o_data_out.
- Pointer wrap: DEPTH is a power of two, so pointers use natural binary wrap.

Optional Feature:
- Macro SPLITTER_LSB_FIRST_EN.
- Defined: slice k = i_data_in[k*OUTPUT_WIDTH +: OUTPUT_WIDTH], so the LSB slice goes out first.
- Undefined: MSB-first order as above.
- No other behaviour or timing changes.

Test Plan (INPUT_WIDTH=32, OUTPUT_WIDTH=8, DEPTH=2):
1. Hold i_reset_n=0 for 2 cycles with random inputs -> o_out_valid=0, o_data_out=0, o_level=0, o_empty=1, o_in_ready=1.
2. Push 0xAABBCCDD with i_out_ready=1 -> slices 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles starting the cycle after acceptance; o_last only with 0xDD; then o_empty=1.
3. Drop i_out_ready for 3 cycles while 0xBB is presented -> 0xBB, o_out_valid=1 and o_last=0 stay stable; 0xCC follows the cycle after i_out_ready returns high.
4. Push 0x11223344, 0x55667788, 0x99AABBCC with i_out_ready=0 -> first two accepted (o_level=2, o_full=1); third stalls with o_in_ready=0 while 0x11 is presented. After release, all 12 slices emerge in order with no bubbles, and the third word is accepted once the first word's last slice loads.
5. Assert i_flush while 0xCC of 0xAABBCCDD is presented -> next cycle o_out_valid=0, o_level=0, o_empty=1; the next word 0x01020304 starts at 0x01.
6. Build with SPLITTER_LSB_FIRST_EN and push 0xAABBCCDD -> slices 0xDD,0xCC,0xBB,0xAA, o_last with 0xAA.
